// File: rtl/lap_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : lap_stopwatch_core
// Description : Centisecond stopwatch / count-down timer with lap memory and
//               recall. Optional split-time laps when LAP_SPLIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module lap_stopwatch_core #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int LAP_DEPTH   = 4,
    parameter int MIN_MAX     = 59
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           btn_run,
    input  logic                           btn_lap,
    input  logic                           btn_clear,
    input  logic                           mode_down,
    input  logic [5:0]                     load_min,
    input  logic [5:0]                     load_sec,
    output logic [5:0]                     disp_min,
    output logic [5:0]                     disp_sec,
    output logic [6:0]                     disp_csec,
    output logic                           running,
    output logic                           viewing_lap,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_full,
    output logic                           expired
);

    localparam int             c_div       = CLK_FREQ_HZ / TICK_HZ;
    localparam int             c_div_w     = $clog2(c_div);
    localparam int             c_cnt_w     = $clog2(LAP_DEPTH + 1);
    localparam int             c_idx_w     = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [5:0]     c_min_max   = 6'(MIN_MAX);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(LAP_DEPTH);
    localparam logic [c_div_w-1:0] c_tick_last = c_div_w'(c_div - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_exp   = 2'd3;

    // Time words are packed {min[5:0], sec[5:0], csec[6:0]}.
    function automatic logic [18:0] f_inc(input logic [18:0] t);
        logic [5:0] m;
        logic [5:0] s;
        logic [6:0] c;
        {m, s, c} = t;
        if (c != 7'd99) begin
            c = c + 7'd1;
        end else begin
            c = 7'd0;
            if (s != 6'd59) begin
                s = s + 6'd1;
            end else begin
                s = 6'd0;
                m = (m >= c_min_max) ? 6'd0 : m + 6'd1;
            end
        end
        return {m, s, c};
    endfunction

    function automatic logic [18:0] f_dec(input logic [18:0] t);
        logic [5:0] m;
        logic [5:0] s;
        logic [6:0] c;
        {m, s, c} = t;
        if (c != 7'd0) begin
            c = c - 7'd1;
        end else begin
            c = 7'd99;
            if (s != 6'd0) begin
                s = s - 6'd1;
            end else begin
                s = 6'd59;
                m = m - 6'd1;
            end
        end
        return {m, s, c};
    endfunction

    logic [1:0]         r_state;
    logic [18:0]        r_time;
    logic [c_div_w-1:0] r_tick_cnt;
    logic               r_mode_down;
    logic [c_cnt_w-1:0] r_lap_count;
    logic [c_cnt_w-1:0] r_recall;
    logic [18:0]        r_disp;
    logic               r_expired;
    logic [18:0]        r_lap_mem [LAP_DEPTH];

    logic [1:0]         w_state_nxt;
    logic [18:0]        w_time_nxt;
    logic [c_div_w-1:0] w_tick_nxt;
    logic               w_mode_nxt;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [c_cnt_w-1:0] w_recall_nxt;
    logic [c_cnt_w-1:0] w_recall_step;
    logic               w_expired_nxt;
    logic               w_lap_wr;
    logic               w_full;
    logic               w_tick;
    logic               w_run_pulse;
    logic               w_lap_pulse;
    logic               w_clear_act;
    logic               w_time_low;
    logic [5:0]         w_load_min;
    logic [5:0]         w_load_sec;
    logic [18:0]        w_clear_val;
    logic [18:0]        w_disp_nxt;
    logic [18:0]        w_lap_data;
    logic [c_idx_w-1:0] w_rd_idx;
    logic [c_idx_w-1:0] w_wr_idx;

    assign w_load_min = (load_min > c_min_max) ? c_min_max : load_min;
    assign w_load_sec = (load_sec > 6'd59) ? 6'd59 : load_sec;
    assign w_wr_idx   = r_lap_count[c_idx_w-1:0];

    always_comb begin
        w_full        = (r_lap_count == c_depth);
        // Priority clear > run > lap: lower pulses are masked by higher ones.
        w_run_pulse   = btn_run && !btn_clear;
        w_lap_pulse   = btn_lap && !btn_clear && !btn_run;
        w_clear_act   = btn_clear && (r_state != c_st_run);
        w_tick        = (r_state == c_st_run) && (r_tick_cnt == c_tick_last);
        w_time_low    = (r_time[18:7] == 12'd0) && (r_time[6:0] <= 7'd1);
        w_clear_val   = mode_down ? {w_load_min, w_load_sec, 7'd0} : 19'd0;
        w_recall_step = (r_recall == r_lap_count) ? '0 : r_recall + c_cnt_w'(1);

        w_state_nxt   = r_state;
        w_time_nxt    = r_time;
        w_tick_nxt    = r_tick_cnt;
        w_mode_nxt    = r_mode_down;
        w_count_nxt   = r_lap_count;
        w_recall_nxt  = r_recall;
        w_expired_nxt = 1'b0;
        w_lap_wr      = 1'b0;

        case (r_state)
            c_st_run: begin
                w_tick_nxt = w_tick ? '0 : r_tick_cnt + c_div_w'(1);
                if (w_tick) begin
                    if (!r_mode_down) begin
                        w_time_nxt = f_inc(r_time);
                    end else if (w_time_low) begin
                        // Covers both a 00:00.01 decrement and a zero load.
                        w_time_nxt    = '0;
                        w_state_nxt   = c_st_exp;
                        w_expired_nxt = 1'b1;
                    end else begin
                        w_time_nxt = f_dec(r_time);
                    end
                end
                if (w_lap_pulse && !w_full) begin
                    w_lap_wr    = 1'b1;
                    w_count_nxt = r_lap_count + c_cnt_w'(1);
                end
                if (w_run_pulse && !w_expired_nxt) begin
                    w_state_nxt = c_st_pause;
                end
            end
            default: begin
                if (w_clear_act) begin
                    w_state_nxt  = c_st_idle;
                    w_time_nxt   = w_clear_val;
                    w_count_nxt  = '0;
                    w_recall_nxt = '0;
                end else if (w_run_pulse && (r_state != c_st_exp)) begin
                    w_state_nxt  = c_st_run;
                    w_tick_nxt   = '0;
                    w_recall_nxt = '0;
                    if (r_state == c_st_idle) begin
                        w_mode_nxt = mode_down;
                    end
                end else if (w_lap_pulse && (r_lap_count != '0)) begin
                    w_recall_nxt = w_recall_step;
                end
            end
        endcase

        w_rd_idx   = c_idx_w'(w_recall_nxt - c_cnt_w'(1));
        w_disp_nxt = (w_recall_nxt == '0) ? w_time_nxt : r_lap_mem[w_rd_idx];
    end

`ifdef LAP_SPLIT_EN
    logic [18:0] r_split;
    logic [18:0] w_split_nxt;

    // Split counter always counts up; a stored lap restarts it.
    always_comb begin
        w_split_nxt = r_split;
        if (w_clear_act || w_lap_wr) begin
            w_split_nxt = '0;
        end else if (w_tick) begin
            w_split_nxt = f_inc(r_split);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_split <= '0;
        end else begin
            r_split <= w_split_nxt;
        end
    end

    assign w_lap_data = r_split;
`else
    assign w_lap_data = r_time;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_time      <= '0;
            r_tick_cnt  <= '0;
            r_mode_down <= 1'b0;
            r_lap_count <= '0;
            r_recall    <= '0;
            r_disp      <= '0;
            r_expired   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time      <= w_time_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_mode_down <= w_mode_nxt;
            r_lap_count <= w_count_nxt;
            r_recall    <= w_recall_nxt;
            r_disp      <= w_disp_nxt;
            r_expired   <= w_expired_nxt;
        end
    end

    // Entries are invalidated through lap_count, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_lap_wr) begin
            r_lap_mem[w_wr_idx] <= w_lap_data;
        end
    end

    assign disp_min    = r_disp[18:13];
    assign disp_sec    = r_disp[12:7];
    assign disp_csec   = r_disp[6:0];
    assign running     = (r_state == c_st_run);
    assign viewing_lap = (r_recall != '0);
    assign lap_count   = r_lap_count;
    assign lap_full    = w_full;
    assign expired     = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_lap_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_lap_stopwatch_core
// Description : Scoreboard bench for lap_stopwatch_core (DIV=10, 4 laps,
//               MIN_MAX=1); expected lap values follow LAP_SPLIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lap_stopwatch_core;

    localparam int CLK_FREQ_HZ = 1000;
    localparam int TICK_HZ     = 100;
    localparam int LAP_DEPTH   = 4;
    localparam int MIN_MAX     = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       mode_down = 1'b0;
    logic [5:0] load_min = 6'd0;
    logic [5:0] load_sec = 6'd0;
    logic [5:0] disp_min;
    logic [5:0] disp_sec;
    logic [6:0] disp_csec;
    logic       running;
    logic       viewing_lap;
    logic [2:0] lap_count;
    logic       lap_full;
    logic       expired;

    lap_stopwatch_core #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .TICK_HZ    (TICK_HZ),
        .LAP_DEPTH  (LAP_DEPTH),
        .MIN_MAX    (MIN_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_run    (btn_run),
        .btn_lap    (btn_lap),
        .btn_clear  (btn_clear),
        .mode_down  (mode_down),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .disp_min   (disp_min),
        .disp_sec   (disp_sec),
        .disp_csec  (disp_csec),
        .running    (running),
        .viewing_lap(viewing_lap),
        .lap_count  (lap_count),
        .lap_full   (lap_full),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [5:0] m;
        logic [5:0] s;
        logic [6:0] c;
        logic       run;
        logic       view;
        logic [2:0] cnt;
        logic       full;
        logic       ex;
    } exp_t;

    exp_t sb_q[$];
    int   exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compares the display/status outputs in the cycle
    // each expectation was queued for.
    always @(negedge clk) begin : mon_state
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (e.cyc == cyc &&
                {disp_min, disp_sec, disp_csec, running, viewing_lap, lap_count, lap_full, expired} ===
                {e.m, e.s, e.c, e.run, e.view, e.cnt, e.full, e.ex}) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d:%0d.%0d run=%0b view=%0b laps=%0d full=%0b exp=%0b, want %0d:%0d.%0d run=%0b view=%0b laps=%0d full=%0b exp=%0b (cyc %0d want %0d)",
                         e.name, disp_min, disp_sec, disp_csec, running, viewing_lap, lap_count, lap_full, expired,
                         e.m, e.s, e.c, e.run, e.view, e.cnt, e.full, e.ex, cyc, e.cyc);
            end
        end
    end

    // Every observed expiry pulse must match a queued expected cycle.
    always @(negedge clk) begin : mon_expired
        if (expired === 1'b1) begin
            n_checks++;
            if (exp_q.size() > 0 && exp_q[0] == cyc) begin
                void'(exp_q.pop_front());
                n_pass++;
            end else begin
                $display("FAIL expired_pulse: expired=1 at cyc %0d, want pulse at cyc %0d",
                         cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit r, input bit l, input bit c);
        btn_run   = r;
        btn_lap   = l;
        btn_clear = c;
        step(1);
        btn_run   = 1'b0;
        btn_lap   = 1'b0;
        btn_clear = 1'b0;
    endtask

    task automatic expect_now(input string name, input int m, input int s, input int c,
                              input bit run, input bit view, input int cnt, input bit full,
                              input bit ex);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.m    = 6'(m);
        e.s    = 6'(s);
        e.c    = 7'(c);
        e.run  = run;
        e.view = view;
        e.cnt  = 3'(cnt);
        e.full = full;
        e.ex   = ex;
        sb_q.push_back(e);
        if (ex) exp_q.push_back(cyc);
    endtask

    // Expected lap contents: absolute time, or split time with LAP_SPLIT_EN.
`ifdef LAP_SPLIT_EN
    localparam int LB_S = 0, LB_C = 2, LC_S = 0, LC_C = 3, LD_S = 0, LD_C = 4, L2_C = 50;
`else
    localparam int LB_S = 1, LB_C = 2, LC_S = 1, LC_C = 5, LD_S = 1, LD_C = 9, L2_C = 80;
`endif

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        step(3);
        expect_now("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Count-up basics.
        pulse(1, 0, 0);
        expect_now("run_start", 0, 0, 0, 1, 0, 0, 0, 0);
        step(10);
        expect_now("first_tick", 0, 0, 1, 1, 0, 0, 0, 0);
        step(990);
        expect_now("hundred_ticks", 0, 1, 0, 1, 0, 0, 0, 0);

        // Five laps in RUN; the fifth is dropped.
        pulse(0, 1, 0);
        expect_now("lap_a", 0, 1, 0, 1, 0, 1, 0, 0);
        step(19);
        pulse(0, 1, 0);
        expect_now("lap_b", 0, 1, 2, 1, 0, 2, 0, 0);
        step(29);
        pulse(0, 1, 0);
        expect_now("lap_c", 0, 1, 5, 1, 0, 3, 0, 0);
        step(39);
        pulse(0, 1, 0);
        expect_now("lap_d_full", 0, 1, 9, 1, 0, 4, 1, 0);
        step(9);
        pulse(0, 1, 0);
        expect_now("lap_e_dropped", 0, 1, 10, 1, 0, 4, 1, 0);

        // Pause and recall all entries, then back to live.
        pulse(1, 0, 0);
        expect_now("pause", 0, 1, 10, 0, 0, 4, 1, 0);
        pulse(0, 1, 0);
        expect_now("recall_0", 0, 1, 0, 0, 1, 4, 1, 0);
        pulse(0, 1, 0);
        expect_now("recall_1", 0, LB_S, LB_C, 0, 1, 4, 1, 0);
        pulse(0, 1, 0);
        expect_now("recall_2", 0, LC_S, LC_C, 0, 1, 4, 1, 0);
        pulse(0, 1, 0);
        expect_now("recall_3", 0, LD_S, LD_C, 0, 1, 4, 1, 0);
        pulse(0, 1, 0);
        expect_now("recall_live", 0, 1, 10, 0, 0, 4, 1, 0);

        // Clear beats run in PAUSE.
        pulse(1, 0, 1);
        expect_now("clear_run_pause", 0, 0, 0, 0, 0, 0, 0, 0);
        step(20);
        expect_now("idle_holds", 0, 0, 0, 0, 0, 0, 0, 0);

        // Clear ignored in RUN.
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        step(9);
        expect_now("clear_in_run", 0, 0, 1, 1, 0, 0, 0, 0);
        pulse(1, 0, 0);
        expect_now("pause2", 0, 0, 1, 0, 0, 0, 0, 0);

        // Count-down from 00:01.00 to expiry.
        mode_down = 1'b1;
        load_min  = 6'd0;
        load_sec  = 6'd1;
        pulse(0, 0, 1);
        expect_now("load_down", 0, 1, 0, 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        mode_down = 1'b0;
        expect_now("down_start", 0, 1, 0, 1, 0, 0, 0, 0);
        step(999);
        expect_now("down_last", 0, 0, 1, 1, 0, 0, 0, 0);
        step(1);
        expect_now("down_expire", 0, 0, 0, 0, 0, 0, 0, 1);
        pulse(1, 0, 0);
        expect_now("run_ignored_exp", 0, 0, 0, 0, 0, 0, 0, 0);
        pulse(0, 0, 1);
        expect_now("clear_exp", 0, 0, 0, 0, 0, 0, 0, 0);

        // Count-up carry into minutes from a loaded 00:59.00.
        mode_down = 1'b1;
        load_min  = 6'd0;
        load_sec  = 6'd59;
        pulse(0, 0, 1);
        mode_down = 1'b0;
        expect_now("load_59", 0, 59, 0, 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        step(999);
        expect_now("up_59_99", 0, 59, 99, 1, 0, 0, 0, 0);
        step(1);
        expect_now("up_carry_min", 1, 0, 0, 1, 0, 0, 0, 0);
        pulse(1, 0, 0);

        // Clamped load 05:63 -> 01:59, then minute wrap at MIN_MAX.
        mode_down = 1'b1;
        load_min  = 6'd5;
        load_sec  = 6'd63;
        pulse(0, 0, 1);
        mode_down = 1'b0;
        expect_now("load_clamped", 1, 59, 0, 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        step(999);
        expect_now("up_1_59_99", 1, 59, 99, 1, 0, 0, 0, 0);
        step(1);
        expect_now("min_wrap", 0, 0, 0, 1, 0, 0, 0, 0);

        // Laps at 00:00.30 and 00:00.80, recall, resume, then reset mid-RUN.
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        step(300);
        pulse(0, 1, 0);
        expect_now("lap_030", 0, 0, 30, 1, 0, 1, 0, 0);
        step(499);
        pulse(0, 1, 0);
        expect_now("lap_080", 0, 0, 80, 1, 0, 2, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        expect_now("recall_030", 0, 0, 30, 0, 1, 2, 0, 0);
        pulse(0, 1, 0);
        expect_now("recall_second", 0, 0, L2_C, 0, 1, 2, 0, 0);
        pulse(1, 0, 0);
        expect_now("run_forces_live", 0, 0, 80, 1, 0, 2, 0, 0);
        reset = 1'b1;
        step(1);
        expect_now("reset_mid_run", 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        pulse(0, 1, 0);
        expect_now("lap_empty_ignored", 0, 0, 0, 0, 0, 0, 0, 0);

        step(3);
        while (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL %s: got no comparison, want compare at cyc %0d", sb_q[0].name, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        while (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL expired_missing: got no pulse, want pulse at cyc %0d", exp_q[0]);
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
